// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: ALU control encodings, func/alu_op constants, MULT/DIV FSM states and the decode helper
// Used by md_sequencer and alu_control_seq (optional feature macro ALU_CTRL_STALL_CNT_EN lives in the top).
package alu_ctrl_pkg;
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd4;
    localparam logic [3:0] ALU_OR   = 4'd5;
    localparam logic [3:0] ALU_XOR  = 4'd6;
    localparam logic [3:0] ALU_NOR  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;
    localparam logic [3:0] ALU_SLL  = 4'd10;
    localparam logic [3:0] ALU_SRL  = 4'd11;
    localparam logic [3:0] ALU_SRA  = 4'd12;

    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLTU = 6'b101011;
    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SRA  = 6'b000011;
    localparam logic [5:0] F_MULT = 6'b011000;
    localparam logic [5:0] F_DIV  = 6'b011010;

    localparam logic [1:0] OP_ADD   = 2'd0;
    localparam logic [1:0] OP_SUB   = 2'd1;
    localparam logic [1:0] OP_RTYPE = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} md_state_t;

    // MULT/DIV decode to ADD (0): they leave the ALU idle while the sequencer runs
    function automatic logic [3:0] decode(input logic [1:0] op, input logic [5:0] f);
        if (op == OP_SUB) return ALU_SUB;
        if (op != OP_RTYPE) return ALU_ADD;
        case (f)
            F_SUB:   return ALU_SUB;
            F_AND:   return ALU_AND;
            F_OR:    return ALU_OR;
            F_XOR:   return ALU_XOR;
            F_NOR:   return ALU_NOR;
            F_SLT:   return ALU_SLT;
            F_SLTU:  return ALU_SLTU;
            F_SLL:   return ALU_SLL;
            F_SRL:   return ALU_SRL;
            F_SRA:   return ALU_SRA;
            default: return ALU_ADD;
        endcase
    endfunction
endpackage

// File: rtl/alu_control_seq_md_sequencer.sv
// md_sequencer: MULT/DIV multi-cycle FSM and cycle counter
// Ports: clk, rst_n (async active-low), start (MULT/DIV offered), is_div, flush,
//        stall (busy in MUL/DIV), md_start (accept pulse), md_is_div, hilo_we (result pulse).
module md_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic is_div,
    input  logic flush,
    output logic stall,
    output logic md_start,
    output logic md_is_div,
    output logic hilo_we
);
    localparam int MX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MX) + 1;

    md_state_t       state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            accept;

    assign stall   = (state == S_MUL) || (state == S_DIV);
    assign hilo_we = state == S_DONE;
    // flush beats a simultaneous accept; stall blocks accept while busy
    assign accept  = start && !flush && !stall;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            S_MUL, S_DIV: begin
                if (flush) state_n = S_IDLE;
                else if (cnt == '0) state_n = S_DONE;
                else cnt_n = cnt - 1'b1;
            end
            default: begin
                state_n = accept ? (is_div ? S_DIV : S_MUL) : S_IDLE;
                cnt_n   = !accept ? cnt : is_div ? CW'(DIV_CYCLES - 1) : CW'(MUL_CYCLES - 1);
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            md_start  <= 1'b0;
            md_is_div <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            md_start <= accept;
            if (accept) md_is_div <= is_div;
        end
    end
endmodule

// File: rtl/alu_control_seq.sv
// alu_control_seq: ALU control decode with ID/EX register and MULT/DIV stall sequencer
// Ports: clk, rst_n (async active-low), in_valid, flush, alu_op[1:0], func[5:0],
//        alu_control[CTRL_W-1:0], ex_valid, md_start, md_is_div, stall, hilo_we.
// Macro ALU_CTRL_STALL_CNT_EN adds stall_cycles[31:0], a saturating count of stalled cycles.
module alu_control_seq
    import alu_ctrl_pkg::*;
#(
    parameter int CTRL_W     = 4,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              flush,
    input  logic [1:0]        alu_op,
    input  logic [5:0]        func,
    output logic [CTRL_W-1:0] alu_control,
    output logic              ex_valid,
    output logic              md_start,
    output logic              md_is_div,
    output logic              stall,
    output logic              hilo_we
`ifdef ALU_CTRL_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cycles
`endif
);
    logic is_md;

    assign is_md = (alu_op == OP_RTYPE) && ((func == F_MULT) || (func == F_DIV));

    md_sequencer #(.MUL_CYCLES(MUL_CYCLES), .DIV_CYCLES(DIV_CYCLES)) u_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (in_valid && is_md),
        .is_div    (func == F_DIV),
        .flush     (flush),
        .stall     (stall),
        .md_start  (md_start),
        .md_is_div (md_is_div),
        .hilo_we   (hilo_we)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_control <= '0;
            ex_valid    <= 1'b0;
        end else if (!stall) begin
            alu_control <= (flush || !in_valid) ? '0 : CTRL_W'(decode(alu_op, func));
            ex_valid    <= in_valid && !flush;
        end
    end

`ifdef ALU_CTRL_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cycles <= '0;
        else if (stall && !(&stall_cycles)) stall_cycles <= stall_cycles + 32'd1;
    end
`endif
endmodule

// File: tb/tb_alu_control_seq.sv
// tb_alu_control_seq: scoreboard bench for alu_control_seq (default parameters)
module tb_alu_control_seq;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       flush = 1'b0;
    logic [1:0] alu_op = 2'd0;
    logic [5:0] func = 6'd0;
    logic [3:0] alu_control;
    logic       ex_valid, md_start, md_is_div, stall, hilo_we;
`ifdef ALU_CTRL_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif
    int n_cmp = 0;
    int n_err = 0;
    logic [8:0] q[$];
    wire  [8:0] obs = {alu_control, ex_valid, md_start, md_is_div, stall, hilo_we};

    localparam logic [5:0] MULT = 6'b011000;
    localparam logic [5:0] DIV  = 6'b011010;
    localparam logic [5:0] XOR  = 6'b100110;

    always #5 clk = ~clk;

    alu_control_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .flush       (flush),
        .alu_op      (alu_op),
        .func        (func),
        .alu_control (alu_control),
        .ex_valid    (ex_valid),
        .md_start    (md_start),
        .md_is_div   (md_is_div),
        .stall       (stall),
        .hilo_we     (hilo_we)
`ifdef ALU_CTRL_STALL_CNT_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] e(input logic [3:0] c, input logic ev, ms, dv, st, hw);
        return {c, ev, ms, dv, st, hw};
    endfunction

    task automatic test_reset;
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'($urandom); flush = 1'($urandom);
            alu_op = 2'($urandom); func = 6'($urandom);
            step;
            n_cmp++;
            if (obs !== 9'd0) begin n_err++; $display("FAIL reset_hold cycle %0d: got %b want 0", i, obs); end
        end
`ifdef ALU_CTRL_STALL_CNT_EN
        n_cmp++;
        if (stall_cycles !== 32'd0) begin n_err++; $display("FAIL reset_stall_cycles: got %0d want 0", stall_cycles); end
`endif
        in_valid = 0; flush = 0; alu_op = 0; func = 0;
        rst_n = 1'b1;
        step;
        in_valid = 1; alu_op = 2; func = DIV;
        step;
        in_valid = 0;
        repeat (4) step;
        n_cmp++;
        if (stall !== 1'b1) begin n_err++; $display("FAIL reset_pre_div_stall: got %b want 1", stall); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs !== 9'd0) begin n_err++; $display("FAIL reset_mid_div: got %b want 0", obs); end
        step; step;
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step;
            n_cmp++;
            if (hilo_we !== 1'b0 || stall !== 1'b0) begin
                n_err++; $display("FAIL reset_no_hilo cycle %0d: got hilo_we=%b stall=%b want 0 0", i, hilo_we, stall);
            end
        end
    endtask

    task automatic test_decode;
        logic [5:0] ft[14] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b100111, 6'b101010,
                               6'b101011, 6'b000000, 6'b000010, 6'b000011, 6'b111111, 6'b100110, 6'b100111};
        logic [3:0] et[14] = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd0, 4'd6, 4'd0};
        logic [1:0] ot[3] = '{2'd0, 2'd1, 2'd3};
        logic [3:0] eo[3] = '{4'd0, 4'd1, 4'd0};
        logic [8:0] x;
        for (int i = 0; i < 14; i++) begin
            // last entry is a flushed XOR-then-NOR pair: the flush must bubble
            in_valid = 1; alu_op = 2; func = ft[i]; flush = (i == 13);
            q.push_back(e(et[i], i != 13, 0, 0, 0, 0));
            step;
            x = q.pop_front();
            n_cmp++;
            if (obs !== x) begin n_err++; $display("FAIL decode func=%b: got %b want %b", ft[i], obs, x); end
        end
        flush = 0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; alu_op = ot[i]; func = (i == 0) ? MULT : 6'($urandom);
            q.push_back(e(eo[i], 1, 0, 0, 0, 0));
            step;
            x = q.pop_front();
            n_cmp++;
            if (obs !== x) begin n_err++; $display("FAIL decode alu_op=%0d: got %b want %b", ot[i], obs, x); end
        end
        in_valid = 0; alu_op = 0; func = 0;
        q.push_back(e(0, 0, 0, 0, 0, 0));
        step;
        x = q.pop_front();
        n_cmp++;
        if (obs !== x) begin n_err++; $display("FAIL decode_bubble: got %b want %b", obs, x); end
    endtask

    task automatic test_mult;
        logic [8:0] x;
        int c = 0;
        q.push_back(e(0, 1, 1, 0, 1, 0));
        repeat (3) q.push_back(e(0, 1, 0, 0, 1, 0));
        q.push_back(e(0, 1, 0, 0, 0, 1));
        q.push_back(e(0, 0, 0, 0, 0, 0));
        in_valid = 1; alu_op = 2; func = MULT;
        while (q.size() != 0) begin
            step; c++;
            in_valid = 0;
            x = q.pop_front();
            n_cmp++;
            if (obs !== x) begin n_err++; $display("FAIL mult cycle %0d: got %b want %b", c, obs, x); end
        end
    endtask

    task automatic test_back_to_back;
        logic [8:0] x;
        int c = 0;
        q.push_back(e(0, 1, 1, 0, 1, 0));
        repeat (3) q.push_back(e(0, 1, 0, 0, 1, 0));
        q.push_back(e(0, 1, 0, 0, 0, 1));
        q.push_back(e(0, 1, 1, 1, 1, 0));
        repeat (31) q.push_back(e(0, 1, 0, 1, 1, 0));
        q.push_back(e(0, 1, 0, 1, 0, 1));
        q.push_back(e(0, 0, 0, 1, 0, 0));
        in_valid = 1; alu_op = 2; func = MULT;
        while (q.size() != 0) begin
            step; c++;
            in_valid = (c == 5); func = DIV;
            x = q.pop_front();
            n_cmp++;
            if (obs !== x) begin n_err++; $display("FAIL back_to_back cycle %0d: got %b want %b", c, obs, x); end
        end
    endtask

    task automatic test_flush;
        logic [8:0] x;
        int c = 0;
        q.push_back(e(0, 1, 1, 1, 1, 0));
        repeat (9) q.push_back(e(0, 1, 0, 1, 1, 0));
        q.push_back(e(0, 1, 0, 1, 0, 0));
        repeat (30) q.push_back(e(0, 0, 0, 1, 0, 0));
        in_valid = 1; alu_op = 2; func = DIV;
        while (q.size() != 0) begin
            step; c++;
            in_valid = 0;
            flush = (c == 10) || (c == 11);
            x = q.pop_front();
            n_cmp++;
            if (obs !== x) begin n_err++; $display("FAIL flush_div cycle %0d: got %b want %b", c, obs, x); end
        end
        flush = 0;
    endtask

    task automatic test_stall_hold;
        logic [8:0] x;
        int c = 0;
`ifdef ALU_CTRL_STALL_CNT_EN
        logic [31:0] sc0 = stall_cycles;
`endif
        q.push_back(e(0, 1, 1, 0, 1, 0));
        repeat (3) q.push_back(e(0, 1, 0, 0, 1, 0));
        q.push_back(e(0, 1, 0, 0, 0, 1));
        q.push_back(e(6, 1, 0, 0, 0, 0));
        q.push_back(e(0, 0, 0, 0, 0, 0));
        in_valid = 1; alu_op = 2; func = MULT;
        while (q.size() != 0) begin
            step; c++;
            if (c < 5) begin
                in_valid = 1'($urandom); alu_op = 2'($urandom); func = (c == 2) ? DIV : 6'($urandom);
            end else begin
                in_valid = (c == 5); alu_op = 2; func = XOR;
            end
            x = q.pop_front();
            n_cmp++;
            if (obs !== x) begin n_err++; $display("FAIL stall_hold cycle %0d: got %b want %b", c, obs, x); end
        end
`ifdef ALU_CTRL_STALL_CNT_EN
        n_cmp++;
        if (stall_cycles - sc0 !== 32'd4) begin
            n_err++; $display("FAIL stall_cycles_delta: got %0d want 4", stall_cycles - sc0);
        end
`endif
    endtask

    initial begin
        test_reset;
        test_decode;
        test_mult;
        test_back_to_back;
        test_flush;
        test_stall_hold;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/alu_control_seq.md
Name: alu_control_seq

Overview:
- Next-generation ALU control for the MIPS pipeline.
- Decodes alu_op/func into a CTRL_W-bit ALU control word registered into the EX stage, with an extended R-type set (xor, nor, slt, sltu, shifts).
- Adds a multi-cycle sequencer for MULT/DIV: stalls the pipeline for a parametrised number of cycles, then pulses the HI/LO write enable.

Parameters:
- CTRL_W, 4, width of ALU control word.
- MUL_CYCLES, 4, EX cycles a MULT occupies (legal range >=1).
- DIV_CYCLES, 32, EX cycles a DIV occupies (legal range >=1).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  decoded instruction present at ID/EX boundary.
- flush  input  1  squash the instruction entering EX and abort any MULT/DIV in progress.
- alu_op  input  2  main-decoder ALU class.
- func  input  6  R-type function field.
- alu_control  output  CTRL_W  registered ALU control word for EX.
- ex_valid  output  1  registered; alu_control holds a live instruction.
- md_start  output  1  one-cycle pulse: MULT/DIV accepted.
- md_is_div  output  1  registered; 1 = DIV, 0 = MULT, valid from md_start until hilo_we.
- stall  output  1  freeze IF/ID and ID/EX; high while MULT/DIV executes.
- hilo_we  output  1  one-cycle pulse: HI/LO result ready.

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: alu_control=0, ex_valid=0, md_start=0, md_is_div=0, stall=0, hilo_we=0.
  - FSM enters IDLE; counter cleared.
  - Reset mid-MULT/DIV aborts the operation with no hilo_we.
- Decode (combinational, internal):
  - alu_op=0 -> 0 (ADD); alu_op=1 -> 1 (SUB); alu_op=3 -> 0.
  - alu_op=2, by func: 100000 -> 0 ADD; 100010 -> 1 SUB; 100100 -> 4 AND; 100101 -> 5 OR; 100110 -> 6 XOR; 100111 -> 7 NOR; 101010 -> 8 SLT; 101011 -> 9 SLTU; 000000 -> 10 SLL; 000010 -> 11 SRL; 000011 -> 12 SRA; 011000 -> MULT; 011010 -> DIV; any other func -> 0.
  - Encodings are zero-extended to CTRL_W.
- Register update, evaluated at each rising edge:
  - stall=1: alu_control and ex_valid hold.
  - Else if flush=1 or in_valid=0: alu_control=0, ex_valid=0 (bubble).
  - Else: alu_control=decode, ex_valid=1. For MULT/DIV, alu_control=0.
  - Latency: one cycle from inputs to alu_control.
- FSM states: IDLE, MUL, DIV, DONE.
  - Accept condition: stall=0, in_valid=1, flush=0, alu_op=2, func=MULT/DIV.
  - On accept: go to MUL/DIV; counter=N-1 (N=MUL_CYCLES or DIV_CYCLES); md_is_div set.
  - md_start is registered and high for the first cycle of MUL/DIV.
  - In MUL/DIV: stall=1 (combinational from state). Counter decrements; when counter=0, next state is DONE. Stall is therefore high for exactly N cycles.
  - DONE: hilo_we=1, stall=0, lasting one cycle. Next state is IDLE, or MUL/DIV directly if a new MULT/DIV is accepted that cycle (back-to-back).
  - flush during MUL/DIV: next state IDLE; no hilo_we; stall drops the following cycle.
  - flush wins over a simultaneous accept.
  - in_valid/func changes during stall are ignored.
- Counter width: $clog2(max(MUL_CYCLES,DIV_CYCLES))+1; no wrap possible.

Optional Feature:
- Macro: ALU_CTRL_STALL_CNT_EN.
- Defined:
  - Adds output stall_cycles[31:0], reset to 0.
  - Increments each cycle stall=1; saturates at 32'hFFFFFFFF.
  - Not cleared by flush.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package alu_ctrl_pkg holds:
  - ALU control encodings (ADD..SRA).
  - func constants.
  - alu_op class constants.
  - FSM state typedef (IDLE/MUL/DIV/DONE).
- Sub-module md_sequencer holds the FSM + counter; ports start, is_div, flush, stall, md_start, hilo_we.
- Top holds decode and the ID/EX control register.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> all outputs 0. Assert rst_n=0 mid-DIV -> stall falls immediately and no hilo_we follows.
- Decode sweep: alu_op=2 with each func in the table, plus func=6'b111111 -> alu_control equals the table value one cycle later, ex_valid=1. alu_op=0/1/3 -> 0/1/0.
- MULT, MUL_CYCLES=4: accept at edge k -> md_start high cycle k+1, stall high cycles k+1..k+4, hilo_we high cycle k+5 only, md_is_div=0.
- Back-to-back: DIV presented during the MULT DONE cycle -> DIV accepted with no extra bubble; stall high for DIV_CYCLES=32 cycles; then hilo_we; md_is_div=1.
- Flush mid-DIV at cycle 10 of 32 -> stall low next cycle, no hilo_we ever, FSM IDLE, alu_control=0/ex_valid=0.
- Stall hold: change func/in_valid every cycle during MULT -> alu_control/ex_valid unchanged until stall drops. With ALU_CTRL_STALL_CNT_EN defined, stall_cycles=4 after one MULT.
